// File: rtl/mips_mul_pkg.sv
// Function codes shared between ALU control and the multiply unit,
// plus the multiply FSM state encoding.
package mips_mul_pkg;

    localparam logic [5:0] FN_MULTU     = 6'b011001;
    localparam logic [5:0] FN_MADDU     = 6'b011100;
    localparam logic [5:0] FN_MFHI      = 6'b010000;
    localparam logic [5:0] FN_MFLO      = 6'b010010;
    localparam logic [5:0] FN_MULTU_OUT = 6'b111111;
    localparam logic [5:0] FN_MADDU_OUT = 6'b111110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic is_mul_start(input logic [5:0] code);
        return (code == FN_MULTU) || (code == FN_MADDU);
    endfunction

endpackage

// File: rtl/multu_hilo_unit_if.sv
// Execute-stage connection to the multiply unit: function code and operands in,
// read data, status and HI/LO contents out.
interface multu_hilo_unit_if #(parameter int WIDTH = 32);

    logic [5:0]       Signal;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output Signal, a, b,
        input  result, busy, done, hi, lo
    );

    modport slave (
        input  Signal, a, b,
        output result, busy, done, hi, lo
    );

endinterface

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add multiply datapath. A load performs step 0 on the operands
// directly, so the product is complete after WIDTH load/step edges.
module mul_shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               clear,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] src_mcand;
    logic [WIDTH-1:0]   src_mplier;
    logic [2*WIDTH-1:0] src_acc;
    logic [2*WIDTH-1:0] partial;

    always_comb begin
        src_mcand  = load ? {{WIDTH{1'b0}}, a} : mcand_q;
        src_mplier = load ? b : mplier_q;
        src_acc    = load ? '0 : acc;
        partial    = src_mplier[0] ? src_mcand : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load || step) begin
            acc      <= src_acc + partial;
            mcand_q  <= src_mcand << 1;
            mplier_q <= src_mplier >> 1;
        end
    end

endmodule

// File: rtl/multu_hilo_unit.sv
// MULTU/MADDU sequencer and HI/LO register file with MFHI/MFLO read mux.
//   state   | meaning
//   ST_IDLE | waiting for MULTU/MADDU
//   ST_RUN  | one shift-add step per edge while Signal holds the latched op
//   ST_DONE | product in acc, waiting for the matching commit code
module multu_hilo_unit
    import mips_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic               clk,
    input logic               reset,
    multu_hilo_unit_if.slave  bus
);

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] hilo_d;
    logic [2*WIDTH-1:0] acc;
    logic               load, step, clear, hilo_we;

    mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .clear (clear),
        .a     (bus.a),
        .b     (bus.b),
        .acc   (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        load    = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        hilo_we = 1'b0;
        hilo_d  = {hi_q, lo_q};
        case (state_q)
            ST_IDLE: begin
                if (is_mul_start(bus.Signal)) begin
                    load    = 1'b1;
                    op_d    = bus.Signal;
                    cnt_d   = 6'd1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.Signal != op_q) begin
                    clear   = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.Signal == op_q) begin
                    state_d = ST_DONE;
                end else if (is_mul_start(bus.Signal)) begin
                    load    = 1'b1;
                    op_d    = bus.Signal;
                    cnt_d   = 6'd1;
                    state_d = ST_RUN;
                end else begin
                    // Commit, mismatched commit and unrelated codes all end the product.
                    clear   = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                    if (bus.Signal == FN_MULTU_OUT && op_q == FN_MULTU) begin
                        hilo_we = 1'b1;
                        hilo_d  = acc;
                    end else if (bus.Signal == FN_MADDU_OUT && op_q == FN_MADDU) begin
                        hilo_we = 1'b1;
                        hilo_d  = {hi_q, lo_q} + acc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= FN_MULTU;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            if (hilo_we) begin
                {hi_q, lo_q} <= hilo_d;
            end
        end
    end

    always_comb begin
        case (bus.Signal)
            FN_MFHI: bus.result = hi_q;
            FN_MFLO: bus.result = lo_q;
            default: bus.result = '0;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench: table of multiply/commit vectors with hand-computed HI/LO,
// followed by hold, restart, abort and reset-in-flight sequences.
module tb_multu_hilo_unit;
    import mips_mul_pkg::*;

    localparam logic [5:0] FN_ADD = 6'b100000;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    multu_hilo_unit_if #(.WIDTH(32)) bus ();

    multu_hilo_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  start;
        logic [5:0]  commit;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_mul(input int idx, input vec_t v);
        bus.Signal = v.start;
        bus.a      = v.a;
        bus.b      = v.b;
        tick();
        check($sformatf("v%0d busy after start", idx), 64'(bus.busy), 64'd1);
        bus.a = ~v.a;
        bus.b = ~v.b;
        repeat (30) tick();
        check($sformatf("v%0d done after edge 31", idx), 64'(bus.done), 64'd0);
        tick();
        check($sformatf("v%0d done after edge 32", idx), 64'(bus.done), 64'd1);
        check($sformatf("v%0d busy after edge 32", idx), 64'(bus.busy), 64'd0);
        bus.Signal = v.commit;
        tick();
        check($sformatf("v%0d hi", idx), 64'(bus.hi), 64'(v.hi));
        check($sformatf("v%0d lo", idx), 64'(bus.lo), 64'(v.lo));
        check($sformatf("v%0d done after commit", idx), 64'(bus.done), 64'd0);
        bus.Signal = FN_MFLO;
        #1;
        check($sformatf("v%0d mflo", idx), 64'(bus.result), 64'(v.lo));
        bus.Signal = FN_MFHI;
        #1;
        check($sformatf("v%0d mfhi", idx), 64'(bus.result), 64'(v.hi));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{FN_MULTU, FN_MULTU_OUT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{FN_MULTU, FN_MULTU_OUT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{FN_MULTU, FN_MULTU_OUT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[3] = '{FN_MADDU, FN_MADDU_OUT, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
        vecs[4] = '{FN_MULTU, FN_MULTU_OUT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5] = '{FN_MADDU, FN_MADDU_OUT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6] = '{FN_MADDU, FN_MADDU_OUT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[7] = '{FN_MULTU, FN_MULTU_OUT, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 32'hEADB_EEF0};
        vecs[8] = '{FN_MULTU, FN_MULTU_OUT, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[9] = '{FN_MADDU, FN_MADDU_OUT, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};

        reset      = 1'b1;
        bus.Signal = FN_ADD;
        bus.a      = '0;
        bus.b      = '0;
        tick();
        tick();
        reset = 1'b0;
        bus.Signal = FN_MFHI;
        #1;
        check("reset mfhi", 64'(bus.result), 64'd0);
        bus.Signal = FN_MFLO;
        #1;
        check("reset mflo", 64'(bus.result), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_mul(i, vecs[i]);
        end

        // Hold in DONE, then mismatched commit: no write.
        bus.Signal = FN_MULTU;
        bus.a      = 32'd2;
        bus.b      = 32'd3;
        repeat (32) tick();
        check("hold done", 64'(bus.done), 64'd1);
        repeat (3) tick();
        check("hold done after 3", 64'(bus.done), 64'd1);
        check("hold busy", 64'(bus.busy), 64'd0);
        bus.Signal = FN_MADDU_OUT;
        tick();
        check("mismatch done", 64'(bus.done), 64'd0);
        check("mismatch hilo", {bus.hi, bus.lo}, 64'h0000_0000_FFFE_0001);

        // Other-kind start in DONE restarts with fresh operands.
        bus.Signal = FN_MULTU;
        repeat (32) tick();
        check("restart pre done", 64'(bus.done), 64'd1);
        bus.Signal = FN_MADDU;
        bus.a      = 32'd6;
        bus.b      = 32'd7;
        tick();
        check("restart busy", 64'(bus.busy), 64'd1);
        check("restart done", 64'(bus.done), 64'd0);
        repeat (31) tick();
        check("restart done after 32", 64'(bus.done), 64'd1);
        bus.Signal = FN_MADDU_OUT;
        tick();
        check("restart hilo", {bus.hi, bus.lo}, 64'h0000_0000_FFFE_002B);

        // Abort at edge 10, then a lone commit is ignored.
        bus.Signal = FN_MULTU;
        bus.a      = 32'd7;
        bus.b      = 32'd9;
        repeat (9) tick();
        check("abort busy before", 64'(bus.busy), 64'd1);
        bus.Signal = FN_ADD;
        tick();
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        bus.Signal = FN_MULTU_OUT;
        tick();
        check("abort hilo", {bus.hi, bus.lo}, 64'h0000_0000_FFFE_002B);
        check("abort idle busy", 64'(bus.busy), 64'd0);

        // Reset at edge 20 of RUN clears HI/LO; following commit writes nothing.
        bus.Signal = FN_MULTU;
        bus.a      = 32'd5;
        bus.b      = 32'd5;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst run busy", 64'(bus.busy), 64'd0);
        check("rst run done", 64'(bus.done), 64'd0);
        check("rst run hilo", {bus.hi, bus.lo}, 64'd0);
        bus.Signal = FN_MULTU_OUT;
        tick();
        check("rst commit hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst commit done", 64'(bus.done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
